// File: rtl/dsp_4bits_seq_alu_if.sv
// Wrapper-style 8-in/8-out bus for the serial 4-bit ALU.
// The clock, reset and enable are packed into io_in together with the data nibble.
interface dsp_4bits_seq_alu_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (
    output io_in,
    input  io_out
  );

  modport slave (
    input  io_in,
    output io_out
  );
endinterface

// File: rtl/dsp_4bits_seq_alu.sv
// Serial 4-bit ALU: accepts opcode, A and B nibbles in turn.
// The result and its Z/C/N/V flags are registered on the edge that accepts B.
module dsp_4bits_seq_alu (
  dsp_4bits_seq_alu_if.slave bus
);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpXor = 4'h4;
  localparam logic [3:0] OpNot = 4'h5;
  localparam logic [3:0] OpNeg = 4'h6;
  localparam logic [3:0] OpInc = 4'h7;
  localparam logic [3:0] OpDec = 4'h8;
  localparam logic [3:0] OpShl = 4'h9;
  localparam logic [3:0] OpShr = 4'hA;
  localparam logic [3:0] OpAsr = 4'hB;
  localparam logic [3:0] OpRol = 4'hC;
  localparam logic [3:0] OpRor = 4'hD;
  localparam logic [3:0] OpMul = 4'hE;
  localparam logic [3:0] OpCmp = 4'hF;

  typedef enum logic [1:0] {StOp, StA, StB} state_e;

  logic       clk;
  logic       rst_n;
  logic       enabled;
  logic [3:0] din;
  logic       unused_io;

  assign clk       = bus.io_in[0];
  assign rst_n     = bus.io_in[1];
  assign enabled   = bus.io_in[2];
  assign din       = bus.io_in[7:4];
  assign unused_io = bus.io_in[3];

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;
  logic [3:0] a_q, a_d;
  logic [7:0] out_q, out_d;

  // ALU datapath; B is taken straight from the bus on the accepting edge.
  logic [4:0] sum;
  logic [4:0] diff;
  logic [7:0] prod;
  logic       add_v;
  logic       sub_v;
  logic [3:0] alu_r;
  logic [3:0] alu_zn;
  logic       alu_c;
  logic       alu_v;

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, din};
    diff  = {1'b0, a_q} - {1'b0, din};
    prod  = {4'b0000, a_q} * {4'b0000, din};
    add_v = ~(a_q[3] ^ din[3]) & (sum[3] ^ a_q[3]);
    sub_v = (a_q[3] ^ din[3]) & (diff[3] ^ a_q[3]);

    alu_r = 4'h0;
    alu_c = 1'b0;
    alu_v = 1'b0;

    unique case (opcode_q)
      OpAdd: begin
        alu_r = sum[3:0];
        alu_c = sum[4];
        alu_v = add_v;
      end
      OpSub: begin
        alu_r = diff[3:0];
        alu_c = diff[4];
        alu_v = sub_v;
      end
      OpAnd: alu_r = a_q & din;
      OpOr:  alu_r = a_q | din;
      OpXor: alu_r = a_q ^ din;
      OpNot: alu_r = ~a_q;
      OpNeg: begin
        alu_r = 4'h0 - a_q;
        alu_c = (a_q != 4'h0);
        alu_v = (a_q == 4'h8);
      end
      OpInc: begin
        alu_r = a_q + 4'h1;
        alu_c = (a_q == 4'hF);
        alu_v = (a_q == 4'h7);
      end
      OpDec: begin
        alu_r = a_q - 4'h1;
        alu_c = (a_q == 4'h0);
        alu_v = (a_q == 4'h8);
      end
      OpShl: begin
        alu_r = {a_q[2:0], 1'b0};
        alu_c = a_q[3];
      end
      OpShr: begin
        alu_r = {1'b0, a_q[3:1]};
        alu_c = a_q[0];
      end
      OpAsr: begin
        alu_r = {a_q[3], a_q[3:1]};
        alu_c = a_q[0];
      end
      OpRol: begin
        alu_r = {a_q[2:0], a_q[3]};
        alu_c = a_q[3];
      end
      OpRor: begin
        alu_r = {a_q[0], a_q[3:1]};
        alu_c = a_q[0];
      end
      OpMul: begin
        alu_r = prod[3:0];
        alu_c = (prod[7:4] != 4'h0);
      end
      OpCmp: begin
        alu_r = a_q;
        alu_c = diff[4];
        alu_v = sub_v;
      end
      default: ;
    endcase

    // CMP reports A on the bus but flags the difference.
    alu_zn = (opcode_q == OpCmp) ? diff[3:0] : alu_r;
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    out_d    = out_q;

    if (enabled) begin
      unique case (state_q)
        StOp: begin
          opcode_d = din;
          state_d  = StA;
        end
        StA: begin
          a_d     = din;
          state_d = StB;
        end
        StB: begin
          out_d   = {alu_v, alu_zn[3], alu_c, (alu_zn == 4'h0), alu_r};
          state_d = StOp;
        end
        default: state_d = StOp;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StOp;
      opcode_q <= 4'h0;
      a_q      <= 4'h0;
      out_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      out_q    <= out_d;
    end
  end

  assign bus.io_out = out_q;

endmodule

// File: tb/tb_dsp_4bits_seq_alu.sv
// Directed and randomised checks of the serial 4-bit ALU against a reference model.
module tb_dsp_4bits_seq_alu;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] nib;

  int ncomp;
  int nfail;
  logic [7:0] hold_val;
  logic [7:0] exp_q[$];

  dsp_4bits_seq_alu_if bus ();

  assign bus.io_in = {nib, 1'b0, en, rst_n, clk};

  dsp_4bits_seq_alu dut (
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: integer arithmetic with explicit signed interpretation.
  function automatic logic [7:0] model(input int op, input int a, input int b);
    int r, zn, c, v, sa, sb, sr, p;
    logic [3:0] rr;
    logic [3:0] zz;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c = 0;
    v = 0;
    r = 0;
    case (op)
      0: begin
        r = (a + b) % 16; c = (a + b > 15) ? 1 : 0;
        sr = sa + sb; v = (sr > 7 || sr < -8) ? 1 : 0;
      end
      1, 15: begin
        r = (a - b + 16) % 16; c = (a < b) ? 1 : 0;
        sr = sa - sb; v = (sr > 7 || sr < -8) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin r = (16 - a) % 16; c = (a != 0) ? 1 : 0; v = (a == 8) ? 1 : 0; end
      7: begin r = (a + 1) % 16; c = (a == 15) ? 1 : 0; v = (a == 7) ? 1 : 0; end
      8: begin r = (a + 15) % 16; c = (a == 0) ? 1 : 0; v = (a == 8) ? 1 : 0; end
      9: begin r = (a * 2) % 16; c = a / 8; end
      10: begin r = a / 2; c = a % 2; end
      11: begin r = a / 2 + ((a >= 8) ? 8 : 0); c = a % 2; end
      12: begin r = (a * 2) % 16 + a / 8; c = a / 8; end
      13: begin r = a / 2 + (a % 2) * 8; c = a % 2; end
      14: begin p = a * b; r = p % 16; c = (p > 15) ? 1 : 0; end
      default: r = 0;
    endcase
    zn = r;
    if (op == 15) r = a;
    rr = r[3:0];
    zz = zn[3:0];
    return {v[0], (zn >= 8) ? 1'b1 : 1'b0, c[0], (zn == 0) ? 1'b1 : 1'b0, rr};
  endfunction

  task automatic check(input string tag, input logic [7:0] expv);
    logic [7:0] got;
    got = bus.io_out;
    ncomp++;
    assert (got === expv)
    else begin
      nfail++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stall_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      en  = 1'b0;
      nib = 4'($urandom_range(0, 15));
      tick();
      check("stall_hold", hold_val);
    end
  endtask

  // Sends one full operation; expected output is queued as the B nibble is driven.
  task automatic send(input int op, input int a, input int b, input int stall);
    logic [7:0] expv;
    stall_cycles(stall);
    en = 1'b1; nib = 4'(op);
    tick();
    check("hold_after_op", hold_val);
    stall_cycles(stall);
    en = 1'b1; nib = 4'(a);
    tick();
    check("hold_after_a", hold_val);
    stall_cycles(stall);
    en = 1'b1; nib = 4'(b);
    exp_q.push_back(model(op, a, b));
    tick();
    en = 1'b0;
    expv = exp_q.pop_front();
    check($sformatf("result op=%0h a=%0h b=%0h", op, a, b), expv);
    hold_val = expv;
  endtask

  initial begin
    ncomp    = 0;
    nfail    = 0;
    hold_val = 8'h00;
    rst_n    = 1'b0;
    en       = 1'b0;
    nib      = 4'h0;

    tick();
    tick();
    check("reset", 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_after_reset", 8'h00);
    end

    send(0, 7, 9, 0);  check("add_7_9", 8'h30);
    send(0, 7, 1, 0);  check("add_7_1", 8'hC8);
    send(1, 3, 5, 0);  check("sub_3_5", 8'h6E);
    send(15, 5, 5, 0); check("cmp_5_5", 8'h15);
    send(14, 5, 3, 0); check("mul_5_3", 8'h4F);
    send(14, 6, 5, 0); check("mul_6_5", 8'h6E);
    send(0, 2, 3, 4);  check("add_stalled", 8'h05);

    // Reset in the middle of a sequence must return to the opcode slot.
    en = 1'b1; nib = 4'h0; tick();
    nib = 4'h4; tick();
    rst_n = 1'b0; nib = 4'h9; tick();
    check("mid_reset", 8'h00);
    hold_val = 8'h00;
    rst_n = 1'b1; en = 1'b0;
    send(1, 6, 2, 0);  check("sub_after_reset", 8'h04);
    send(9, 9, 0, 0);  check("shl_9", 8'h22);
    send(13, 1, 0, 0); check("ror_1", 8'h68);

    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 4; k++) begin
        send(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 1)));
      end
    end
    send(6, 8, 0, 0);
    send(6, 0, 0, 0);
    send(7, 15, 0, 0);
    send(8, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
